// File: rtl/swervolf_rd_arb.sv
// swervolf_rd_arb
// Two-master AXI4 read-channel arbiter in front of the single LiteDRAM read
// port. AR requests from the SweRV core path (master 0) and a second
// requester (master 1) are granted round-robin. Each granted request is
// tagged with its master index in the slave-side ID MSB. R beats are routed
// back by that MSB. Each master has a cap on reads that have been accepted
// but not yet completed.
//
// Handshake semantics on every channel: a transfer happens on a rising clk
// edge where valid and ready are both high. A source that raises valid keeps
// valid and payload stable until that transfer. Ready may depend
// combinationally on valid, but valid never depends on ready from the same
// interface.

module swervolf_rd_arb #(
  parameter int ID_WIDTH        = 6,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  // Master-side AR: master n payload at slice n
  input  logic [2*(ID_WIDTH+ADDR_WIDTH+13)-1:0]         i_m_ar,
  input  logic [1:0]                                    i_m_arvalid,
  output logic [1:0]                                    o_m_arready,
  // Master-side R: payload broadcast, valid steered by ID MSB
  output logic [ID_WIDTH+DATA_WIDTH+2:0]                o_m_r,
  output logic [1:0]                                    o_m_rvalid,
  input  logic [1:0]                                    i_m_rready,
  // Slave-side AR
  output logic [ID_WIDTH+ADDR_WIDTH+13:0]               o_s_ar,
  output logic                                          o_s_arvalid,
  input  logic                                          i_s_arready,
  // Slave-side R
  input  logic [ID_WIDTH+DATA_WIDTH+3:0]                i_s_r,
  input  logic                                          i_s_rvalid,
  output logic                                          o_s_rready,
  // Sticky protocol error: R last for a master with nothing outstanding
  output logic                                          o_err
);

  localparam int ARW = ID_WIDTH + ADDR_WIDTH + 13;   // master AR payload width
  localparam int RMW = ID_WIDTH + DATA_WIDTH + 3;    // master R payload width
  localparam int RSW = RMW + 1;                      // slave R payload width
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);  // outstanding counter width

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Outstanding read count per master
  logic [CW-1:0]  cnt [2];

  // AR side
  logic [1:0]     elig;         // master has a request and room for one more read
  logic           ar_free;      // holding register can take a new request this cycle
  logic           grant_any;    // some master is granted this cycle
  logic           sel;          // index of the granted master
  logic           prio;         // master favoured when both are eligible
  logic [ARW-1:0] sel_payload;  // AR payload of the granted master
  logic [1:0]     ar_hs;        // per-master AR handshake

  // Holding register behind o_s_ar / o_s_arvalid
  logic           s_arvalid_q;
  logic [ARW:0]   s_ar_q;

  // R side
  logic           r_mst;        // master addressed by the current beat
  logic           r_last;       // current beat closes its burst
  logic           r_hs;         // beat handshake on the slave side
  logic [1:0]     r_done;       // per-master burst completion this cycle

  logic           err_q;

  // Eligibility: pending request and counter below the cap
  always_comb begin
    elig = 2'b00;
    for (int n = 0; n < 2; n++) begin
      elig[n] = i_m_arvalid[n] & (cnt[n] < MAX_CNT);
    end
  end

  // Round-robin selection and master AR ready
  always_comb begin
    ar_free   = !s_arvalid_q | i_s_arready;
    // Gated by rstn so no handshake (and no count) happens while in reset
    grant_any = rstn & ar_free & (|elig);
    // Both eligible: the pointer decides; otherwise the only eligible master
    sel       = (&elig) ? prio : elig[1];
    o_m_arready = {grant_any & sel, grant_any & !sel};
    ar_hs       = o_m_arready & i_m_arvalid;
    sel_payload = sel ? i_m_ar[2*ARW-1:ARW] : i_m_ar[ARW-1:0];
  end

  // Holding register: load on grant, drain when the slave takes it, else hold
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_arvalid_q <= 1'b0;
      s_ar_q      <= '0;
      prio        <= 1'b0;
    end else if (ar_free) begin
      if (grant_any) begin
        s_arvalid_q <= 1'b1;
        s_ar_q      <= {sel, sel_payload};
        // Favour the other master next time both compete
        prio        <= ~sel;
      end else begin
        s_arvalid_q <= 1'b0;
      end
    end
  end

  assign o_s_arvalid = s_arvalid_q;
  assign o_s_ar      = s_ar_q;

  // R routing: steer valid by ID MSB, take ready from the addressed master
  always_comb begin
    r_mst      = i_s_r[RSW-1];
    r_last     = i_s_r[0];
    o_m_r      = i_s_r[RMW-1:0];
    o_m_rvalid = r_mst ? {i_s_rvalid, 1'b0} : {1'b0, i_s_rvalid};
    o_s_rready = i_m_rready[r_mst];
    r_hs       = i_s_rvalid & o_s_rready;
    r_done     = {r_hs & r_last & r_mst, r_hs & r_last & !r_mst};
  end

  // Outstanding counters and sticky underflow error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (ar_hs[n] && !r_done[n]) begin
          cnt[n] <= cnt[n] + CNT_ONE;
        end else if (r_done[n] && !ar_hs[n]) begin
          if (cnt[n] == '0) begin
            // Completion with nothing outstanding: saturate and flag
            err_q <= 1'b1;
          end else begin
            cnt[n] <= cnt[n] - CNT_ONE;
          end
        end
      end
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_swervolf_rd_arb.sv
// Directed testbench for swervolf_rd_arb: AR arbitration, stall, outstanding
// cap, R routing/backpressure, sticky error and reset behaviour.

module tb_swervolf_rd_arb;

  localparam int ID_W  = 6;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ARW   = ID_W + ADDR_W + 13;
  localparam int RMW   = ID_W + DATA_W + 3;
  localparam int RSW   = RMW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [2*ARW-1:0] m_ar;
  logic [1:0]       m_arvalid;
  logic [1:0]       m_arready;
  logic [RMW-1:0]   m_r;
  logic [1:0]       m_rvalid;
  logic [1:0]       m_rready;
  logic [ARW:0]     s_ar;
  logic             s_arvalid;
  logic             s_arready;
  logic [RSW-1:0]   s_r;
  logic             s_rvalid;
  logic             s_rready;
  logic             err;

  swervolf_rd_arb #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_m_ar(m_ar), .i_m_arvalid(m_arvalid), .o_m_arready(m_arready),
    .o_m_r(m_r), .o_m_rvalid(m_rvalid), .i_m_rready(m_rready),
    .o_s_ar(s_ar), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .i_s_r(s_r), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .o_err(err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ARW:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [ARW-1:0] mk_ar(input logic [5:0] id, input logic [31:0] addr,
                                           input logic [7:0] len);
    return {id, addr, len, 3'd3, 2'b01};
  endfunction

  function automatic logic [RSW-1:0] mk_sr(input logic m, input logic [5:0] id,
                                           input logic [63:0] data, input logic [1:0] resp,
                                           input logic last);
    return {m, id, data, resp, last};
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow newly driven inputs
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m_ar      = '0;
    m_arvalid = 2'b00;
    m_rready  = 2'b00;
    s_arready = 1'b0;
    s_r       = '0;
    s_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    settle();
  endtask

  // Hard bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [ARW-1:0] ar0, ar1, ar1b, ar0_5;
  logic [RSW-1:0] sr;

  initial begin
    // ============ reset ============
    rstn = 1'b0;
    clear_inputs();
    do_reset();
    chk("rst_arvalid", s_arvalid, 0);
    chk("rst_arready", m_arready, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt0", dut.cnt[0], 0);

    // ============ single master read ============
    ar0 = mk_ar(6'h05, 32'h100, 8'd3);
    m_ar[ARW-1:0] = ar0;
    m_arvalid = 2'b01;
    s_arready = 1'b1;
    m_rready  = 2'b11;
    settle();
    chk("single_arready", m_arready, 2'b01);
    step();
    m_arvalid = 2'b00;
    settle();
    chk("single_arvalid_n1", s_arvalid, 1);
    chk("single_s_ar", s_ar, {1'b0, ar0});
    chk("single_cnt_up", dut.cnt[0], 1);
    step();
    chk("single_arvalid_drop", s_arvalid, 0);
    for (int b = 0; b < 4; b++) begin
      s_r      = mk_sr(1'b0, 6'h05, 64'hA000 + 64'(b), 2'b00, (b == 3));
      s_rvalid = 1'b1;
      settle();
      chk("single_rvalid", m_rvalid, 2'b01);
      chk("single_srready", s_rready, 1);
      chk("single_m_r", m_r, {6'h05, 64'hA000 + 64'(b), 2'b00, (b == 3)});
      chk("single_cnt_hold", dut.cnt[0], 1);
      step();
    end
    s_rvalid = 1'b0;
    settle();
    chk("single_cnt_down", dut.cnt[0], 0);

    // ============ contention ============
    do_reset();
    ar0 = mk_ar(6'h01, 32'hA0, 8'd0);
    ar1 = mk_ar(6'h02, 32'hB0, 8'd1);
    m_ar      = {ar1, ar0};
    m_arvalid = 2'b11;
    s_arready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? {1'b0, ar0} : {1'b1, ar1});
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("cont_arready", m_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("cont_arvalid", s_arvalid, 1);
      chk("cont_s_ar", s_ar, exp_q.pop_front());
    end
    chk("cont_cnt0", dut.cnt[0], 2);
    chk("cont_cnt1", dut.cnt[1], 2);

    // ============ slave stall ============
    ar1b = mk_ar(6'h03, 32'hC0, 8'd2);
    m_ar[2*ARW-1:ARW] = ar1b;
    m_arvalid = 2'b10;
    s_arready = 1'b0;
    settle();
    chk("stall_arready0", m_arready, 2'b00);
    chk("stall_hold0", s_ar, {1'b1, ar1});
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_arready", m_arready, 2'b00);
      chk("stall_hold", s_ar, {1'b1, ar1});
      chk("stall_valid", s_arvalid, 1);
    end
    s_arready = 1'b1;
    settle();
    chk("stall_release_arready", m_arready, 2'b10);
    step();
    chk("stall_new_s_ar", s_ar, {1'b1, ar1b});
    chk("stall_cnt1", dut.cnt[1], 3);
    m_arvalid = 2'b00;
    step();
    chk("stall_drain", s_arvalid, 0);

    // ============ outstanding limit ============
    do_reset();
    ar0 = mk_ar(6'h10, 32'h1000, 8'd0);
    m_ar[ARW-1:0] = ar0;
    m_arvalid = 2'b01;
    s_arready = 1'b1;
    m_rready  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("lim_arready", m_arready, 2'b01);
      step();
    end
    settle();
    chk("lim_cnt_full", dut.cnt[0], 4);
    chk("lim_blocked", m_arready, 2'b00);
    ar0_5 = mk_ar(6'h11, 32'h2000, 8'd0);
    ar1   = mk_ar(6'h20, 32'h3000, 8'd0);
    m_ar  = {ar1, ar0_5};
    m_arvalid = 2'b11;
    settle();
    chk("lim_m1_granted", m_arready, 2'b10);
    step();
    chk("lim_m1_s_ar", s_ar, {1'b1, ar1});
    m_arvalid = 2'b01;
    s_r      = mk_sr(1'b0, 6'h10, 64'h55, 2'b00, 1'b1);
    s_rvalid = 1'b1;
    settle();
    chk("lim_still_blocked", m_arready, 2'b00);
    chk("lim_r_rready", s_rready, 1);
    step();
    s_rvalid = 1'b0;
    settle();
    chk("lim_cnt_after_r", dut.cnt[0], 3);
    chk("lim_unblocked", m_arready, 2'b01);
    step();
    chk("lim_5th_s_ar", s_ar, {1'b0, ar0_5});
    chk("lim_cnt_refull", dut.cnt[0], 4);
    m_arvalid = 2'b00;

    // ============ response routing / backpressure ============
    sr = mk_sr(1'b1, 6'h07, 64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0);
    s_r      = sr;
    s_rvalid = 1'b1;
    m_rready = 2'b01;
    settle();
    chk("route_rvalid", m_rvalid, 2'b10);
    chk("route_bp_rready", s_rready, 0);
    chk("route_m_r", m_r, {6'h07, 64'hDEAD_BEEF_0123_4567, 2'b10, 1'b0});
    m_rready = 2'b11;
    settle();
    chk("route_rready", s_rready, 1);
    chk("route_rvalid_hold", m_rvalid, 2'b10);
    step();
    s_rvalid = 1'b0;
    m_rready = 2'b00;
    settle();
    chk("route_idle", m_rvalid, 2'b00);

    // ============ reset mid-operation ============
    do_reset();
    m_ar[ARW-1:0] = mk_ar(6'h0A, 32'h40, 8'd0);
    m_arvalid = 2'b01;
    s_arready = 1'b0;
    settle();
    chk("mid_arready", m_arready, 2'b01);
    step();
    m_arvalid = 2'b00;
    step();
    chk("mid_held", s_arvalid, 1);
    rstn = 1'b0;
    m_arvalid = 2'b01;
    settle();
    chk("mid_rst_arready", m_arready, 2'b00);
    step();
    chk("mid_rst_valid", s_arvalid, 0);
    chk("mid_rst_cnt", dut.cnt[0], 0);
    rstn = 1'b1;
    m_arvalid = 2'b00;
    s_arready = 1'b1;
    settle();
    chk("err_clear", err, 0);

    // ============ error and simultaneity ============
    s_r      = mk_sr(1'b1, 6'h09, 64'h1, 2'b00, 1'b1);
    s_rvalid = 1'b1;
    m_rready = 2'b11;
    step();
    s_rvalid = 1'b0;
    settle();
    chk("err_set", err, 1);
    chk("err_cnt1_sat", dut.cnt[1], 0);
    step();
    chk("err_sticky", err, 1);
    m_ar[ARW-1:0] = mk_ar(6'h0B, 32'h80, 8'd0);
    m_arvalid = 2'b01;
    step();
    chk("sim_cnt_one", dut.cnt[0], 1);
    s_r      = mk_sr(1'b0, 6'h0B, 64'h2, 2'b00, 1'b1);
    s_rvalid = 1'b1;
    settle();
    chk("sim_arready", m_arready, 2'b01);
    chk("sim_rready", s_rready, 1);
    step();
    m_arvalid = 2'b00;
    s_rvalid  = 1'b0;
    settle();
    chk("sim_cnt_unchanged", dut.cnt[0], 1);
    chk("sim_err_sticky", err, 1);
    rstn = 1'b0;
    step();
    chk("err_reset", err, 0);
    rstn = 1'b1;
    step();

    // ============ final report ============
    chk("exp_q_empty", 128'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
